// File: rtl/wb_trace_uart_tx_if.sv
// Writeback-stage tap and trace status signals shared by the pipeline side and the trace transmitter.
// The transmitter samples the writeback signals and never pushes back on the pipeline.
interface wb_trace_uart_tx_if;
  logic        RegWriteW;
  logic        MemToRegW;
  logic [3:0]  destAddW;
  logic [15:0] MemReadDataW;
  logic [15:0] alu_resultW;
  logic        trace_en;
  logic        clr_overflow;
  logic        tx;
  logic        tx_busy;
  logic        fifo_full;
  logic        overflow;
  logic [1:0]  state_dbg;

  // Handshake: none. A capture is taken on any clock edge where RegWriteW && trace_en;
  // there is no ready signal, so a capture that finds the FIFO full is dropped
  // and recorded in overflow.
  modport master (
    output RegWriteW, MemToRegW, destAddW, MemReadDataW, alu_resultW, trace_en, clr_overflow,
    input  tx, tx_busy, fifo_full, overflow, state_dbg
  );

  modport slave (
    input  RegWriteW, MemToRegW, destAddW, MemReadDataW, alu_resultW, trace_en, clr_overflow,
    output tx, tx_busy, fifo_full, overflow, state_dbg
  );
endinterface

// File: rtl/wb_trace_uart_tx.sv
// Register-write trace: captures retired writes into a FIFO and sends each one as a
// 3-byte 8N1 UART frame {0xA,dest}, wdata[15:8], wdata[7:0].
module wb_trace_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 8,
  parameter int FIFO_AW      = 3
) (
  input  logic               clk,
  input  logic               reset,
  wb_trace_uart_tx_if.slave  bus
);

  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0]  BAUD_LAST     = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0]   FIFO_FULL_CNT = (FIFO_AW + 1)'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [19:0]         fifo_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]    count_q, count_d;
  logic                overflow_q, overflow_d;
  logic [1:0]          state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [2:0]          bit_q, bit_d;
  logic [1:0]          byte_q, byte_d;
  logic [7:0]          shift_q, shift_d;
  logic [15:0]         wdata_q, wdata_d;
  logic                tx_q, tx_d;

  logic        push_req, full, empty, push, pop, drop, baud_done;
  logic [19:0] wr_entry, head;

  always_comb begin
    push_req  = bus.RegWriteW && bus.trace_en;
    full      = (count_q == FIFO_FULL_CNT);
    empty     = (count_q == '0);
    pop       = (state_q == S_IDLE) && !empty;
    // A pop frees a slot in the same cycle, so full-plus-pop never drops.
    push      = push_req && (!full || pop);
    drop      = push_req && full && !pop;
    wr_entry  = {bus.destAddW, bus.MemToRegW ? bus.MemReadDataW : bus.alu_resultW};
    head      = fifo_mem[rd_ptr_q];
    baud_done = (baud_q == BAUD_LAST);
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
    // A new drop outranks a clear in the same cycle.
    overflow_d = drop ? 1'b1 : (bus.clr_overflow ? 1'b0 : overflow_q);
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + 1'b1;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shift_d = shift_q;
    wdata_d = wdata_q;
    tx_d    = tx_q;
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (pop) begin
          wdata_d = head[15:0];
          shift_d = {4'hA, head[19:16]};
          byte_d  = 2'd0;
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (baud_done) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      S_STOP: begin
        if (baud_done) begin
          baud_d = '0;
          if (byte_q < 2'd2) begin
            byte_d  = byte_q + 1'b1;
            shift_d = (byte_q == 2'd0) ? wdata_q[15:8] : wdata_q[7:0];
            state_d = S_START;
            tx_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  // Storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= wr_entry;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_q      <= 3'd0;
      byte_q     <= 2'd0;
      shift_q    <= 8'h00;
      wdata_q    <= 16'h0000;
      tx_q       <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      shift_q    <= shift_d;
      wdata_q    <= wdata_d;
      tx_q       <= tx_d;
    end
  end

  assign bus.tx        = tx_q;
  assign bus.tx_busy   = (state_q != S_IDLE);
  assign bus.fifo_full = full;
  assign bus.overflow  = overflow_q;
  assign bus.state_dbg = state_q;

endmodule
